// File: rtl/shot_pool_if.sv
// Bus between the shot pool and its users: spawn/move/delete controls in,
// registered read port, valid mask and spawn status out.
interface shot_pool_if #(
   parameter int SHOTS = 8,
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int DIR_W = 6,
   parameter int VEL_W = 4
);
   localparam int AW   = (SHOTS > 1) ? $clog2(SHOTS) : 1;
   localparam int CW   = $clog2(SHOTS + 1);
   localparam int RD_W = 1 + X_W + Y_W + DIR_W;

   logic              move_tick;
   logic              shoot;
   logic [X_W-1:0]    spawn_x;
   logic [Y_W-1:0]    spawn_y;
   logic [DIR_W-1:0]  spawn_dir;
   logic [VEL_W-1:0]  spawn_vx;
   logic [VEL_W-1:0]  spawn_vy;
   logic              del_valid;
   logic [AW-1:0]     del_addr;
   logic [AW-1:0]     rd_addr;
   logic [RD_W-1:0]   rd_data;
   logic [SHOTS-1:0]  valid_mask;
   logic [CW-1:0]     active_count;
   logic              spawn_ack;
   logic [AW-1:0]     spawn_slot;
   logic              spawn_drop;

   modport master (
      output move_tick, shoot, spawn_x, spawn_y, spawn_dir, spawn_vx, spawn_vy,
             del_valid, del_addr, rd_addr,
      input  rd_data, valid_mask, active_count, spawn_ack, spawn_slot, spawn_drop
   );

   modport slave (
      input  move_tick, shoot, spawn_x, spawn_y, spawn_dir, spawn_vx, spawn_vy,
             del_valid, del_addr, rd_addr,
      output rd_data, valid_mask, active_count, spawn_ack, spawn_slot, spawn_drop
   );
endinterface

// File: rtl/shot_pool.sv
// Projectile slot pool: allocate on shoot, advance on move_tick, retire on expiry,
// screen exit or delete. Define SHOT_WRAP_EN to wrap off-screen shots instead of freeing them.
module shot_pool #(
   parameter int SHOTS    = 8,
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int DIR_W    = 6,
   parameter int VEL_W    = 4,
   parameter int LIFE_W   = 6,
   parameter int LIFETIME = 40,
   parameter int COOLDOWN = 4,
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479
) (
   input logic        clock,
   input logic        reset_n,
   shot_pool_if.slave bus
);
   localparam int AW   = (SHOTS > 1) ? $clog2(SHOTS) : 1;
   localparam int CW   = $clog2(SHOTS + 1);
   localparam int CDW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int RD_W = 1 + X_W + Y_W + DIR_W;

   logic [SHOTS-1:0]             valid, valid_nx;
   logic [SHOTS-1:0][X_W-1:0]    x, mx;
   logic [SHOTS-1:0][Y_W-1:0]    y, my;
   logic [SHOTS-1:0][DIR_W-1:0]  dir;
   logic [SHOTS-1:0][VEL_W-1:0]  vx, vy;
   logic [SHOTS-1:0][LIFE_W-1:0] life;
   logic [SHOTS-1:0]             off, del_hit, spawn_hit, move_hit;
   logic [CDW-1:0]               cd;
   logic [AW-1:0]                alloc;
   logic                         free_found, spawn_ok;
   logic [CW-1:0]                cnt_nx;

   logic [RD_W-1:0] rd_data_q;
   logic [CW-1:0]   count_q;
   logic            ack_q, drop_q;
   logic [AW-1:0]   slot_q;

   // Lowest free slot, judged on pre-edge valid so a same-cycle delete is not reused.
   always_comb begin
      free_found = 1'b0;
      alloc      = '0;
      for (int i = SHOTS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_found = 1'b1;
            alloc      = AW'(i);
         end
      end
   end

   assign spawn_ok = bus.shoot && (cd == '0) && free_found;

   for (genvar g = 0; g < SHOTS; g++) begin : g_mv
      logic [X_W:0] sx;
      logic [Y_W:0] sy;
      logic         x_lo, x_hi, y_lo, y_hi;
      assign sx   = {1'b0, x[g]} + {{(X_W + 1 - VEL_W){vx[g][VEL_W-1]}}, vx[g]};
      assign sy   = {1'b0, y[g]} + {{(Y_W + 1 - VEL_W){vy[g][VEL_W-1]}}, vy[g]};
      assign x_lo = sx[X_W];
      assign y_lo = sy[Y_W];
      assign x_hi = !sx[X_W] && (sx[X_W-1:0] > X_W'(X_MAX));
      assign y_hi = !sy[Y_W] && (sy[Y_W-1:0] > Y_W'(Y_MAX));
`ifdef SHOT_WRAP_EN
      assign mx[g] = x_lo ? sx[X_W-1:0] + X_W'(X_MAX + 1) :
                     x_hi ? sx[X_W-1:0] - X_W'(X_MAX + 1) : sx[X_W-1:0];
      assign my[g] = y_lo ? sy[Y_W-1:0] + Y_W'(Y_MAX + 1) :
                     y_hi ? sy[Y_W-1:0] - Y_W'(Y_MAX + 1) : sy[Y_W-1:0];
      assign off[g] = 1'b0;
`else
      assign mx[g]  = sx[X_W-1:0];
      assign my[g]  = sy[Y_W-1:0];
      assign off[g] = x_lo | x_hi | y_lo | y_hi;
`endif
      // Deleting a free slot is a no-op, so it never blocks a spawn into that slot.
      assign del_hit[g]   = bus.del_valid && (bus.del_addr == AW'(g)) && valid[g];
      assign spawn_hit[g] = !del_hit[g] && spawn_ok && (alloc == AW'(g));
      assign move_hit[g]  = !del_hit[g] && !spawn_hit[g] && valid[g] && bus.move_tick;
   end

   always_comb begin
      valid_nx = valid;
      cnt_nx   = '0;
      for (int i = 0; i < SHOTS; i++) begin
         if (del_hit[i])
            valid_nx[i] = 1'b0;
         else if (spawn_hit[i])
            valid_nx[i] = 1'b1;
         else if (move_hit[i] && ((life[i] == LIFE_W'(1)) || off[i]))
            valid_nx[i] = 1'b0;
         cnt_nx = cnt_nx + CW'(valid_nx[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid     <= '0;
         x         <= '0;
         y         <= '0;
         dir       <= '0;
         vx        <= '0;
         vy        <= '0;
         life      <= '0;
         cd        <= '0;
         rd_data_q <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         drop_q    <= 1'b0;
         slot_q    <= '0;
      end else begin
         valid <= valid_nx;
         for (int i = 0; i < SHOTS; i++) begin
            if (spawn_hit[i]) begin
               x[i]    <= bus.spawn_x;
               y[i]    <= bus.spawn_y;
               dir[i]  <= bus.spawn_dir;
               vx[i]   <= bus.spawn_vx;
               vy[i]   <= bus.spawn_vy;
               life[i] <= LIFE_W'(LIFETIME);
            end else if (move_hit[i]) begin
               x[i]    <= mx[i];
               y[i]    <= my[i];
               life[i] <= life[i] - LIFE_W'(1);
            end
         end
         if (spawn_ok)
            cd <= CDW'(COOLDOWN);
         else if (bus.move_tick && (cd != '0))
            cd <= cd - CDW'(1);
         ack_q  <= spawn_ok;
         drop_q <= bus.shoot && !spawn_ok;
         if (spawn_ok)
            slot_q <= alloc;
         count_q <= cnt_nx;
         if (int'(bus.rd_addr) < SHOTS)
            rd_data_q <= {valid[bus.rd_addr], x[bus.rd_addr], y[bus.rd_addr], dir[bus.rd_addr]};
         else
            rd_data_q <= '0;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.valid_mask   = valid;
   assign bus.active_count = count_q;
   assign bus.spawn_ack    = ack_q;
   assign bus.spawn_slot   = slot_q;
   assign bus.spawn_drop   = drop_q;
endmodule

// File: tb/tb_shot_pool.sv
// Directed bench: dut_a uses default parameters (cooldown, movement, screen exit),
// dut_b uses COOLDOWN=0, LIFETIME=3 (fill, delete/reuse, expiry).
module tb_shot_pool;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   shot_pool_if ia ();
   shot_pool_if ib ();

   shot_pool dut_a (.clock(clock), .reset_n(reset_n), .bus(ia));
   shot_pool #(.COOLDOWN(0), .LIFETIME(3)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      ia.move_tick = 0; ia.shoot = 0; ia.spawn_x = '0; ia.spawn_y = '0; ia.spawn_dir = '0;
      ia.spawn_vx = '0; ia.spawn_vy = '0; ia.del_valid = 0; ia.del_addr = '0; ia.rd_addr = '0;
      ib.move_tick = 0; ib.shoot = 0; ib.spawn_x = '0; ib.spawn_y = '0; ib.spawn_dir = '0;
      ib.spawn_vx = '0; ib.spawn_vy = '0; ib.del_valid = 0; ib.del_addr = '0; ib.rd_addr = '0;

      step(); step();
      check("rst_mask", ia.valid_mask, 8'h00);
      check("rst_count", ia.active_count, 0);
      check("rst_rd", ia.rd_data, 0);
      check("rst_ack", ia.spawn_ack, 0);
      check("rst_drop", ia.spawn_drop, 0);
      check("rst_mask_b", ib.valid_mask, 8'h00);
      reset_n = 1'b1;

      // dut_a: first spawn and one move
      ia.spawn_x = 10'd100; ia.spawn_y = 9'd200; ia.spawn_dir = 6'd21;
      ia.spawn_vx = 4'h3; ia.spawn_vy = 4'hE;
      ia.shoot = 1; step(); ia.shoot = 0;
      check("a_ack0", ia.spawn_ack, 1);
      check("a_slot0", ia.spawn_slot, 0);
      check("a_mask0", ia.valid_mask, 8'h01);
      check("a_count0", ia.active_count, 1);
      check("a_drop0", ia.spawn_drop, 0);
      ia.move_tick = 1; step(); ia.move_tick = 0;
      step();
      check("a_rd_move", ia.rd_data, {1'b1, 10'd103, 9'd198, 6'd21});

      // cooldown: second tick then shoot is dropped
      ia.spawn_x = 10'd638; ia.spawn_y = 9'd100; ia.spawn_dir = 6'd5;
      ia.spawn_vx = 4'h3; ia.spawn_vy = 4'h0;
      ia.move_tick = 1; step(); ia.move_tick = 0;
      ia.shoot = 1; step(); ia.shoot = 0;
      check("a_cd_drop", ia.spawn_drop, 1);
      check("a_cd_noack", ia.spawn_ack, 0);
      check("a_cd_mask", ia.valid_mask, 8'h01);
      ia.move_tick = 1; step(); step(); ia.move_tick = 0;
      ia.shoot = 1; step(); ia.shoot = 0;
      check("a_cd_ack", ia.spawn_ack, 1);
      check("a_cd_slot", ia.spawn_slot, 1);
      check("a_cd_count", ia.active_count, 2);

      // slot1 leaves the right edge on the next tick
      ia.move_tick = 1; step(); ia.move_tick = 0;
`ifdef SHOT_WRAP_EN
      check("a_edge_mask", ia.valid_mask, 8'h03);
      check("a_edge_count", ia.active_count, 2);
`else
      check("a_edge_mask", ia.valid_mask, 8'h01);
      check("a_edge_count", ia.active_count, 1);
`endif
      ia.rd_addr = 1; step();
`ifdef SHOT_WRAP_EN
      check("a_edge_rd", ia.rd_data, {1'b1, 10'd1, 9'd100, 6'd5});
`else
      check("a_edge_rdv", ia.rd_data[25], 1'b0);
`endif
      ia.rd_addr = 0; step();
      check("a_rd_slot0", ia.rd_data, {1'b1, 10'd115, 9'd190, 6'd21});

      // dut_b: fill the pool, ninth shot dropped
      ib.spawn_x = 10'd50; ib.spawn_y = 9'd60;
      ib.shoot = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("b_fill_ack", ib.spawn_ack, 1);
         check("b_fill_slot", ib.spawn_slot, i);
      end
      step();
      check("b_full_drop", ib.spawn_drop, 1);
      check("b_full_ack", ib.spawn_ack, 0);
      check("b_full_count", ib.active_count, 8);
      check("b_full_mask", ib.valid_mask, 8'hFF);

      // delete slot 5 while shooting: freed slot not reused until next cycle
      ib.del_valid = 1; ib.del_addr = 3'd5; step(); ib.del_valid = 0;
      check("b_del_mask", ib.valid_mask, 8'hDF);
      check("b_del_drop", ib.spawn_drop, 1);
      check("b_del_count", ib.active_count, 7);
      step(); ib.shoot = 0;
      check("b_reuse_ack", ib.spawn_ack, 1);
      check("b_reuse_slot", ib.spawn_slot, 5);
      check("b_reuse_mask", ib.valid_mask, 8'hFF);

      // lifetime 3: all expire on the third tick
      ib.move_tick = 1;
      step(); check("b_life1", ib.valid_mask, 8'hFF);
      step(); check("b_life2", ib.valid_mask, 8'hFF);
      step(); check("b_life3", ib.valid_mask, 8'h00);
      check("b_life3_count", ib.active_count, 0);

      // spawn with move_tick high: not moved that cycle, lives three more ticks
      ib.shoot = 1; step(); ib.shoot = 0;
      check("b_sm_ack", ib.spawn_ack, 1);
      check("b_sm_slot", ib.spawn_slot, 0);
      step(); step();
      check("b_sm_alive", ib.valid_mask, 8'h01);
      step();
      check("b_sm_dead", ib.valid_mask, 8'h00);
      ib.move_tick = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/shot_pool.md
# shot_pool

Parametrised pool of SHOTS projectile slots for the asteroids game core. Allocates a free slot when the ship fires, advances every live shot by its stored velocity on each movement tick, retires shots on lifetime expiry, screen exit or explicit delete (collision), and exposes a registered read port plus a valid mask to the VGA draw and collision logic.

## Interface

Parameters:
- SHOTS, 8: number of slots, 1..32.
- X_W, 10: x coordinate width.
- Y_W, 9: y coordinate width.
- DIR_W, 6: direction code width, stored for the renderer only.
- VEL_W, 4: signed per-axis velocity width, two's complement.
- LIFE_W, 6: lifetime counter width.
- LIFETIME, 40: move ticks a shot lives, 1..2^LIFE_W-1.
- COOLDOWN, 4: move ticks between accepted spawns; 0 disables cooldown.
- X_MAX, 639: last visible column. Y_MAX, 479: last visible row.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- move_tick  in  1  one-cycle pulse; advance all shots.
- shoot  in  1  spawn request, sampled every cycle.
- spawn_x / spawn_y  in  X_W / Y_W  ship tip position.
- spawn_dir  in  DIR_W  ship direction code.
- spawn_vx / spawn_vy  in  VEL_W  signed velocity for the new shot.
- del_valid  in  1  delete request. del_addr  in  $clog2(SHOTS)  slot to delete.
- rd_addr  in  $clog2(SHOTS)  read slot select.
- rd_data  out  1+X_W+Y_W+DIR_W  {valid, x, y, dir} of rd_addr.
- valid_mask  out  SHOTS  bit i = slot i live.
- active_count  out  $clog2(SHOTS+1)  popcount of valid_mask.
- spawn_ack  out  1  pulse: spawn accepted. spawn_slot  out  $clog2(SHOTS)  slot used.
- spawn_drop  out  1  pulse: spawn rejected (pool full or cooldown active).

## Operation

- Per-slot state: valid, x, y, dir, vx, vy, life. Cooldown counter cd global.
- Reset (reset_n=0 at clock edge): all valid=0, all fields 0, cd=0, rd_data=0, valid_mask=0, active_count=0, spawn_ack=0, spawn_drop=0.
- Spawn: shoot=1 with cd=0 and at least one slot free (current valid=0) -> lowest-index free slot loaded with spawn fields, life=LIFETIME, valid=1; cd loaded with COOLDOWN. Otherwise spawn_drop.
- Move: on move_tick, every live slot not spawned this cycle: x+=vx, y+=vy computed in signed X_W+1 / Y_W+1; life-=1. Slot freed if life reaches 0. Off-screen handling (x<0, x>X_MAX, y<0, y>Y_MAX) per Configuration.
- cd decrements on move_tick when nonzero; a spawn in the same cycle reloads it.
- Delete: del_valid -> slot del_addr valid=0 (fields retained, ignored). Deleting a free slot is a no-op.
- Per-slot priority: reset > delete > spawn > move/expiry. Allocator uses pre-edge valid, so a slot freed by delete this cycle is not reused until next cycle.
- Spawned shot is not moved on the cycle it spawns, even if move_tick=1.

## Timing

- shoot sampled at edge n -> slot valid, spawn_ack/spawn_slot or spawn_drop asserted for one cycle after edge n (visible cycle n+1).
- valid_mask and active_count registered, consistent with slot state after the same edge.
- rd_data registered: rd_addr at edge n -> data of slot state after edge n-1, visible cycle n+1 (1-cycle latency).
- Move/delete effects visible the cycle after the sampling edge.

## Configuration

- SHOT_WRAP_EN defined: off-screen coordinate wraps (x<0 -> x+X_MAX+1; x>X_MAX -> x-X_MAX-1; same for y); shot stays live until lifetime or delete.
- Undefined (default): any off-screen result frees the slot on that tick.

## Test plan

- Reset then shoot=1 one cycle at (100,200), vx=3, vy=-2 -> spawn_ack, spawn_slot=0, valid_mask=1, active_count=1; one move_tick -> rd_data slot0 = {1,103,198,dir}.
- SHOTS=8, COOLDOWN=0: nine shoot pulses -> slots 0..7 acked in order, ninth gives spawn_drop, active_count=8.
- COOLDOWN=4: shoot, then shoot after 2 move_ticks -> spawn_drop; after 4 ticks -> spawn_ack.
- LIFETIME=3, vx=vy=0: spawn, 3 move_ticks -> valid drops after third tick, active_count=0.
- x=638, vx=+3, one tick -> without SHOT_WRAP_EN slot freed; with it x=1, still valid.
- Pool full, del_valid addr=5 and shoot same cycle -> slot 5 freed, spawn_drop; next-cycle shoot -> spawn_slot=5.
